// File: rtl/rv_mc_pkg.sv
// Shared encodings for the rv_mc_ctl multicycle RV32I control unit:
// FSM states, opcode/funct fields and datapath mux selects.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_LSW_ADDR  = 4'd2,
    S_LW_MEM    = 4'd3,
    S_LW_WB     = 4'd4,
    S_SW_MEM    = 4'd5,
    S_ALU_EXEC  = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BR_EXEC   = 4'd8,
    S_JAL_EXEC  = 4'd9,
    S_JALR_EXEC = 4'd10,
    S_LUI_WB    = 4'd11,
    S_TRAP      = 4'd12,
    S_MUL_EXEC  = 4'd13
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_ALU  = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;

  localparam logic [1:0] WB_PC     = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_MDR    = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] ALUA_REG = 2'd0;
  localparam logic [1:0] ALUA_PCC = 2'd1;
  localparam logic [1:0] ALUB_REG = 2'd0;
  localparam logic [1:0] ALUB_IMM = 2'd1;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_MEM_TO  = 2'd2;

  // Anything not recognised here falls through to an illegal-instruction trap.
  function automatic state_e decode_next(input logic [6:0] opcode, input logic [2:0] funct3,
                                         input logic [6:0] funct7, input logic mul_en);
    case (opcode)
      OPC_LOAD, OPC_STORE: return (funct3 == F3_W) ? S_LSW_ADDR : S_TRAP;
      OPC_OP: begin
        if (funct7 == F7_MULDIV) return mul_en ? S_MUL_EXEC : S_TRAP;
        return S_ALU_EXEC;
      end
      OPC_OPIMM:  return S_ALU_EXEC;
      OPC_BRANCH: return (funct3[2:1] == 2'b01) ? S_TRAP : S_BR_EXEC;
      OPC_JAL:    return S_JAL_EXEC;
      OPC_JALR:   return (funct3 == F3_JALR) ? S_JALR_EXEC : S_TRAP;
      OPC_LUI:    return S_LUI_WB;
      default:    return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/rv_mc_ctl_br_cmp.sv
// Branch-taken evaluation from funct3 and the ALU equal/less-than flags.
module rv_mc_br_cmp
  import rv_mc_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = !zero_i;
      F3_BLT:  taken_o = lt_i;
      F3_BGE:  taken_o = !lt_i;
      F3_BLTU: taken_o = ltu_i;
      F3_BGEU: taken_o = !ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctl.sv
// Multicycle RV32I control FSM with memory-access timeout trap.
// Define RV_MC_CTL_MUL_EN to add the MUL_EXEC state and mul_start/mul_done handshake.
module rv_mc_ctl
  import rv_mc_pkg::*;
#(
  parameter int MEM_TO_CYC = 15,
  parameter int TO_W       = $clog2(MEM_TO_CYC + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [1:0]  pcsource,
  output logic        pcwrite,
  output logic        pccen,
  output logic        irwrite,
  output logic        mdrwrite,
  output logic        regwen,
  output logic [1:0]  wbsel,
  output logic [2:0]  immsel,
  output logic [1:0]  asel,
  output logic [1:0]  bsel,
  output logic [3:0]  alusel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [3:0]  state_o
`ifdef RV_MC_CTL_MUL_EN
  ,
  output logic        mul_start,
  input  logic        mul_done
`endif
);

`ifdef RV_MC_CTL_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif
  // Last wait cycle index: a still-pending access here is abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TO_CYC - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic            br_taken, to_hit;
  logic            unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  assign to_hit       = (to_cnt_q == TO_LAST);
  assign state_o      = state_q;
  assign trap_cause   = cause_q;

  rv_mc_br_cmp u_br_cmp (
    .funct3_i (funct3),
    .zero_i   (zero),
    .lt_i     (lt),
    .ltu_i    (ltu),
    .taken_o  (br_taken)
  );

`ifdef RV_MC_CTL_MUL_EN
  logic mul_busy_q;
  always_ff @(posedge clk) begin
    if (!rst_n) mul_busy_q <= 1'b0;
    else        mul_busy_q <= (state_q == S_MUL_EXEC);
  end
`endif

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    pcsource = PC_INC;
    wbsel    = WB_PC;
    immsel   = IMM_I;
    asel     = ALUA_REG;
    bsel     = ALUB_REG;
    alusel   = ALU_ADD;
    pcwrite  = 1'b0;
    pccen    = 1'b0;
    irwrite  = 1'b0;
    mdrwrite = 1'b0;
    regwen   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    trap     = 1'b0;
`ifdef RV_MC_CTL_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        irwrite = 1'b1;
        if (mem_ready) begin
          pcwrite = 1'b1;
          pccen   = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TO;
        end
      end
      S_DECODE: begin
        asel    = ALUA_PCC;
        bsel    = ALUB_IMM;
        immsel  = IMM_B;
        state_d = decode_next(opcode, funct3, funct7, MUL_EN);
        if (state_d == S_TRAP) cause_d = CAUSE_ILLEGAL;
      end
      S_LSW_ADDR: begin
        bsel    = ALUB_IMM;
        immsel  = (opcode == OPC_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OPC_STORE) ? S_SW_MEM : S_LW_MEM;
      end
      S_LW_MEM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          mdrwrite = 1'b1;
          state_d  = S_LW_WB;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TO;
        end
      end
      S_SW_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TO;
        end
      end
      S_LW_WB: begin
        wbsel   = WB_MDR;
        regwen  = 1'b1;
        state_d = S_FETCH;
      end
      S_ALU_EXEC: begin
        if (opcode == OPC_OP) begin
          alusel = {funct3, instr[30]};
        end else begin
          bsel   = ALUB_IMM;
          alusel = {funct3, (funct3 == F3_SR) ? instr[30] : 1'b0};
        end
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        wbsel   = WB_ALUOUT;
        regwen  = 1'b1;
        state_d = S_FETCH;
      end
      S_BR_EXEC: begin
        alusel   = ALU_SUB;
        pcsource = PC_ALU;
        pcwrite  = br_taken;
        state_d  = S_FETCH;
      end
      S_JAL_EXEC, S_JALR_EXEC: begin
        asel     = (state_q == S_JAL_EXEC) ? ALUA_PCC : ALUA_REG;
        immsel   = (state_q == S_JAL_EXEC) ? IMM_J : IMM_I;
        bsel     = ALUB_IMM;
        pcsource = PC_ALU;
        pcwrite  = 1'b1;
        regwen   = 1'b1;
        state_d  = S_FETCH;
      end
      S_LUI_WB: begin
        wbsel   = WB_IMM;
        immsel  = IMM_U;
        regwen  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap     = 1'b1;
        pcsource = PC_TRAP;
        pcwrite  = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef RV_MC_CTL_MUL_EN
      S_MUL_EXEC: begin
        mul_start = !mul_busy_q;
        if (mul_done) state_d = S_ALU_WB;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Counter restarts on every state change, so each memory state sees a fresh budget.
    to_cnt_d = to_cnt_q;
    if (state_d != state_q)        to_cnt_d = '0;
    else if (mem_req && !mem_ready) to_cnt_d = to_cnt_q + TO_W'(1);

    if (!rst_n) begin
      pcwrite  = 1'b0;
      pccen    = 1'b0;
      irwrite  = 1'b0;
      mdrwrite = 1'b0;
      regwen   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      trap     = 1'b0;
`ifdef RV_MC_CTL_MUL_EN
      mul_start = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      to_cnt_q <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      cause_q  <= cause_d;
    end
  end

endmodule

// File: tb/tb_rv_mc_ctl.sv
// Directed bench for rv_mc_ctl with a per-cycle scoreboard of state and strobes.
module tb_rv_mc_ctl;
  import rv_mc_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero, lt, ltu, mem_ready;
  logic        mem_req, mem_we, pcwrite, pccen, irwrite, mdrwrite, regwen, trap;
  logic [1:0]  pcsource, wbsel, asel, bsel, trap_cause;
  logic [2:0]  immsel;
  logic [3:0]  alusel, state_o;
  logic [7:0]  stb;
`ifdef RV_MC_CTL_MUL_EN
  logic        mul_start, mul_done;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] sb[$];

  assign stb = {pcwrite, pccen, irwrite, mdrwrite, regwen, mem_req, mem_we, trap};

  rv_mc_ctl #(.MEM_TO_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .pcsource   (pcsource),
    .pcwrite    (pcwrite),
    .pccen      (pccen),
    .irwrite    (irwrite),
    .mdrwrite   (mdrwrite),
    .regwen     (regwen),
    .wbsel      (wbsel),
    .immsel     (immsel),
    .asel       (asel),
    .bsel       (bsel),
    .alusel     (alusel),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
`ifdef RV_MC_CTL_MUL_EN
    ,
    .mul_start  (mul_start),
    .mul_done   (mul_done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Strobe bits: {pcwrite, pccen, irwrite, mdrwrite, regwen, mem_req, mem_we, trap}
  task automatic exp_cyc(input string tag, input logic [3:0] st, input logic [7:0] s);
    logic [11:0] e;
    sb.push_back({st, s});
    #1;
    e = sb.pop_front();
    vectors++;
    assert ({state_o, stb} === e) else begin
      miscompares++;
      $error("FAIL %s: state/strobes observed %h required %h", tag, {state_o, stb}, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch_dec(input logic [31:0] ins);
    instr = ins;
    mem_ready = 1'b1;
    exp_cyc("fetch", S_FETCH, 8'hE4);
    chk("fetch_pcsrc", 32'(pcsource), 32'(PC_INC));
    tick();
    mem_ready = 1'b0;
    exp_cyc("decode", S_DECODE, 8'h00);
    chk("decode_mux", 32'({asel, bsel, immsel, alusel}), 32'({ALUA_PCC, ALUB_IMM, IMM_B, ALU_ADD}));
    tick();
  endtask

  task automatic br(input string tag, input logic [31:0] ins, input logic z, input logic l,
                    input logic lu, input logic taken);
    fetch_dec(ins);
    zero = z; lt = l; ltu = lu;
    exp_cyc(tag, S_BR_EXEC, taken ? 8'h80 : 8'h00);
    chk({tag, "_mux"}, 32'({pcsource, alusel}), 32'({PC_ALU, ALU_SUB}));
    tick();
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
  endtask

  task automatic alu(input string tag, input logic [31:0] ins, input logic [1:0] eb,
                     input logic [2:0] ei, input logic [3:0] ea);
    fetch_dec(ins);
    exp_cyc(tag, S_ALU_EXEC, 8'h00);
    chk({tag, "_ctl"}, 32'({bsel, immsel, alusel}), 32'({eb, ei, ea}));
    tick();
    exp_cyc({tag, "_wb"}, S_ALU_WB, 8'h08);
    chk({tag, "_wbsel"}, 32'(wbsel), 32'(WB_ALUOUT));
    tick();
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
`ifdef RV_MC_CTL_MUL_EN
    mul_done = 1'b0;
`endif
    tick();
    exp_cyc("reset", S_FETCH, 8'h00);
    chk("reset_cause", 32'(trap_cause), 32'(CAUSE_NONE));
    rst_n = 1'b1;
    tick();

    // LW with three wait cycles: eight cycles end to end
    fetch_dec(32'h00012083);
    exp_cyc("lw_addr", S_LSW_ADDR, 8'h00);
    chk("lw_addr_mux", 32'({asel, bsel, immsel, alusel}), 32'({ALUA_REG, ALUB_IMM, IMM_I, ALU_ADD}));
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_cyc("lw_wait", S_LW_MEM, 8'h04);
      tick();
    end
    mem_ready = 1'b1;
    exp_cyc("lw_ready", S_LW_MEM, 8'h14);
    tick();
    mem_ready = 1'b0;
    exp_cyc("lw_wb", S_LW_WB, 8'h08);
    chk("lw_wbsel", 32'(wbsel), 32'(WB_MDR));
    tick();

    // SW with mem_ready stuck low: timeout after TO wait cycles
    fetch_dec(32'h00112023);
    exp_cyc("sw_addr", S_LSW_ADDR, 8'h00);
    chk("sw_imm", 32'(immsel), 32'(IMM_S));
    tick();
    for (int i = 0; i < TO; i++) begin
      exp_cyc("sw_wait", S_SW_MEM, 8'h06);
      tick();
    end
    exp_cyc("to_trap", S_TRAP, 8'h81);
    chk("to_cause", 32'(trap_cause), 32'(CAUSE_MEM_TO));
    chk("to_pcsrc", 32'(pcsource), 32'(PC_TRAP));
    tick();
    exp_cyc("to_refetch", S_FETCH, 8'h24);

    // SW completing in the last allowed wait cycle: no trap
    fetch_dec(32'h00112023);
    exp_cyc("sw2_addr", S_LSW_ADDR, 8'h00);
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      exp_cyc("sw2_wait", S_SW_MEM, 8'h06);
      tick();
    end
    mem_ready = 1'b1;
    exp_cyc("sw2_last", S_SW_MEM, 8'h06);
    tick();
    mem_ready = 1'b0;
    exp_cyc("sw2_done", S_FETCH, 8'h24);
    chk("cause_hold", 32'(trap_cause), 32'(CAUSE_MEM_TO));

    // Branches
    br("bgeu_taken", 32'h0020F063, 1'b0, 1'b0, 1'b0, 1'b1);
    br("bgeu_not",   32'h0020F063, 1'b0, 1'b0, 1'b1, 1'b0);
    br("blt_taken",  32'h0020C063, 1'b0, 1'b1, 1'b0, 1'b1);
    br("bne_not",    32'h00209063, 1'b1, 1'b0, 1'b0, 1'b0);

    // Illegal encodings
    fetch_dec(32'hFFFFFFFF);
    exp_cyc("ill_trap", S_TRAP, 8'h81);
    chk("ill_cause", 32'(trap_cause), 32'(CAUSE_ILLEGAL));
    tick();
    exp_cyc("ill_after", S_FETCH, 8'h24);
    fetch_dec(32'h0020A063);
    exp_cyc("br010_trap", S_TRAP, 8'h81);
    tick();

    // ALU decode
    alu("sub",  32'h402081B3, ALUB_REG, IMM_I, 4'b0001);
    alu("srai", 32'h4030D093, ALUB_IMM, IMM_I, 4'b1011);
    alu("addi", 32'h40008093, ALUB_IMM, IMM_I, 4'b0000);

    // Jumps and LUI
    fetch_dec(32'h0000006F);
    exp_cyc("jal", S_JAL_EXEC, 8'h88);
    chk("jal_mux", 32'({pcsource, asel, bsel, immsel, wbsel}), 32'({PC_ALU, ALUA_PCC, ALUB_IMM, IMM_J, WB_PC}));
    tick();
    fetch_dec(32'h000080E7);
    exp_cyc("jalr", S_JALR_EXEC, 8'h88);
    chk("jalr_mux", 32'({pcsource, asel, bsel, immsel, wbsel}), 32'({PC_ALU, ALUA_REG, ALUB_IMM, IMM_I, WB_PC}));
    tick();
    fetch_dec(32'h000010B7);
    exp_cyc("lui", S_LUI_WB, 8'h08);
    chk("lui_mux", 32'({wbsel, immsel}), 32'({WB_IMM, IMM_U}));
    tick();

    // Reset in the middle of a LW wait, then a clean restart
    fetch_dec(32'h00012083);
    exp_cyc("rlw_addr", S_LSW_ADDR, 8'h00);
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_cyc("rlw_wait", S_LW_MEM, 8'h04);
      tick();
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    exp_cyc("rst_mid", S_LW_MEM, 8'h00);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b0;
    exp_cyc("rst_fetch", S_FETCH, 8'h24);
    tick();
    for (int i = 0; i < TO - 2; i++) begin
      exp_cyc("rst_fwait", S_FETCH, 8'h24);
      tick();
    end
    mem_ready = 1'b1;
    exp_cyc("rst_fready", S_FETCH, 8'hE4);
    tick();
    mem_ready = 1'b0;
    exp_cyc("rst_dec", S_DECODE, 8'h00);
    tick();
    exp_cyc("rst_addr", S_LSW_ADDR, 8'h00);
    tick();
    mem_ready = 1'b1;
    exp_cyc("rst_mem", S_LW_MEM, 8'h14);
    tick();
    mem_ready = 1'b0;
    exp_cyc("rst_wb", S_LW_WB, 8'h08);
    tick();

    // MUL encoding
    fetch_dec(32'h023100B3);
`ifdef RV_MC_CTL_MUL_EN
    for (int i = 0; i < 5; i++) begin
      mul_done = (i == 4);
      exp_cyc("mul_exec", S_MUL_EXEC, 8'h00);
      chk("mul_start", 32'(mul_start), (i == 0) ? 32'd1 : 32'd0);
      tick();
    end
    mul_done = 1'b0;
    exp_cyc("mul_wb", S_ALU_WB, 8'h08);
    chk("mul_wbsel", 32'(wbsel), 32'(WB_ALUOUT));
    tick();
`else
    exp_cyc("mul_trap", S_TRAP, 8'h81);
    chk("mul_cause", 32'(trap_cause), 32'(CAUSE_ILLEGAL));
    tick();
`endif
    exp_cyc("final_fetch", S_FETCH, 8'h24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_mc_ctl.md
RV_MC_CTL -- requirements
Module: rv_mc_ctl

Interface
REQ-001 Parameter MEM_TO_CYC, 15, maximum wait cycles on one memory access before a timeout trap (legal range 1..255).
REQ-002 Parameter TO_W, $clog2(MEM_TO_CYC+1), width of the timeout counter.
REQ-003 Ports: clk in 1, the single clock; rst_n in 1, reset, synchronous and active-low.
REQ-004 Ports: instr in 32, current IR contents; zero/lt/ltu in 1 each, ALU flags (equal, signed less-than, unsigned less-than).
REQ-005 Ports: mem_req out 1, memory access request; mem_we out 1, write qualifier; mem_ready in 1, access completes this cycle.
REQ-006 Ports: pcsource out 2 (PC_INC/PC_ALU/PC_TRAP); pcwrite, pccen, irwrite, mdrwrite, regwen out 1 each.
REQ-007 Ports: wbsel out 2 (WB_PC/WB_ALUOUT/WB_MDR/WB_IMM); immsel out 3 (IMM_I/S/B/U/J); asel, bsel out 2 each; alusel out 4.
REQ-008 Ports: trap out 1, one-cycle pulse; trap_cause out 2 (NONE/ILLEGAL/MEM_TO); state_o out 4, current state encoding.

Function
REQ-009 States: FETCH, DECODE, LSW_ADDR, LW_MEM, LW_WB, SW_MEM, ALU_EXEC, ALU_WB, BR_EXEC, JAL_EXEC, JALR_EXEC, LUI_WB, TRAP.
REQ-010 FETCH: mem_req=1 and irwrite=1; hold FETCH until mem_ready=1; in the ready cycle assert pcwrite=1 and pccen=1 with pcsource=PC_INC, then go to DECODE.
REQ-011 DECODE: asel=PCC, bsel=IMM, immsel=IMM_B, alusel=ADD. Next state by {opcode,funct3}: LW/SW->LSW_ADDR; OP/OP-IMM->ALU_EXEC; any BRANCH funct3 except 010/011->BR_EXEC; JAL->JAL_EXEC; JALR->JALR_EXEC; LUI->LUI_WB; everything else->TRAP with cause ILLEGAL.
REQ-012 LSW_ADDR: asel=REG, bsel=IMM, alusel=ADD, immsel=IMM_I for LW and IMM_S for SW; next is LW_MEM or SW_MEM.
REQ-013 LW_MEM and SW_MEM: mem_req=1 (mem_we=1 in SW_MEM only); hold the state until mem_ready=1. LW_MEM asserts mdrwrite=1 in the ready cycle and then goes to LW_WB; SW_MEM goes to FETCH.
REQ-014 LW_WB: wbsel=MDR, regwen=1, next FETCH. ALU_WB: wbsel=ALUOUT, regwen=1, next FETCH. LUI_WB: wbsel=IMM, immsel=IMM_U, regwen=1, next FETCH.
REQ-015 ALU_EXEC: OP gives alusel={funct3,instr[30]}, bsel=REG. OP-IMM gives bsel=IMM, immsel=IMM_I, alusel={funct3, funct3==101 ? instr[30] : 0}. Next ALU_WB.
REQ-016 BR_EXEC: alusel=SUB and pcsource=PC_ALU. Taken when BEQ&zero, BNE&!zero, BLT&lt, BGE&!lt, BLTU&ltu or BGEU&!ltu; pcwrite=1 only when taken. Next FETCH.
REQ-017 JAL_EXEC: asel=PCC, bsel=IMM, immsel=IMM_J, alusel=ADD, pcsource=PC_ALU, pcwrite=1, regwen=1, wbsel=PC. JALR_EXEC is identical except asel=REG and immsel=IMM_I. Both go to FETCH.
REQ-018 Timeout counter: clears on entry to any memory state; increments each cycle with mem_req=1 and mem_ready=0. On reaching MEM_TO_CYC, drop mem_req and go to TRAP with cause MEM_TO. If mem_ready=1 arrives in that same cycle, the access completes and no trap is taken.
REQ-019 TRAP: lasts one cycle; trap=1, pcsource=PC_TRAP, pcwrite=1, regwen=0, mem_req=0; then FETCH. trap_cause holds its value until the next trap.
REQ-020 Outputs are combinational from state, instr and flags. Unlisted controls take these defaults: PC_INC, WB_PC, IMM_I, REG, REG, ADD, and 0 for all others.

Reset
REQ-021 On clk edge with rst_n=0: state=FETCH, timeout counter=0, trap_cause=NONE. This holds even mid-access and even mid-wait; any pending access is abandoned.
REQ-022 While rst_n=0, every strobe (pcwrite, pccen, irwrite, mdrwrite, regwen, mem_req, mem_we, trap) SHALL be 0.

Configuration
REQ-023 With macro RV_MC_CTL_MUL_EN defined: add state MUL_EXEC, reached from DECODE for OP with funct7=0000001, plus ports mul_start out 1 and mul_done in 1. MUL_EXEC pulses mul_start on entry, waits for mul_done, then goes to ALU_WB with wbsel=ALUOUT.
REQ-024 Without RV_MC_CTL_MUL_EN: those ports are absent and funct7=0000001 OP decodes to TRAP ILLEGAL.

Structure
REQ-025 Shared package rv_mc_pkg holds the state enum, opcode/funct3 constants, and the PC_*, WB_*, IMM_*, ALUA_*, ALUB_*, ALU_* and trap-cause encodings.
REQ-026 One sub-module, rv_mc_br_cmp, evaluates the branch-taken condition from funct3 and the three flags.

Verification
REQ-027 LW with mem_ready delayed 3 cycles: FETCH(1)+DECODE+LSW_ADDR+LW_MEM(4)+LW_WB = 8 cycles; regwen in the last cycle only.
REQ-028 BGEU with ltu=0: pcwrite=1 in BR_EXEC. BGEU with ltu=1: pcwrite=0. BLT with lt=1: pcwrite=1.
REQ-029 MEM_TO_CYC=4 and mem_ready stuck at 0 in SW_MEM: TRAP after 4 wait cycles, trap_cause=MEM_TO, mem_we never pulses together with mem_ready.
REQ-030 instr=0xFFFFFFFF: DECODE->TRAP, trap=1 for exactly 1 cycle, cause ILLEGAL, then FETCH.
REQ-031 rst_n=0 during LW_MEM wait: next state FETCH, counter 0, no mdrwrite; the LW restarts cleanly.
REQ-032 MUL build: mul_done after 5 cycles gives ALU_WB; non-MUL build: same instr traps ILLEGAL.
